neuron_state_update: RTL and testbench

- Downstream of the PE conv path: consumes {integrate_sig, out_spike} results, writes membrane potential back to a per-neuron state array, and packs output spikes into words for the next layer's spike buffer.
- A registered read port returns stored vmem so the PE can reload it when accum_src=1.
- Implements reset-by-subtraction or reset-to-zero after a spike.

---
 rtl/neuron_state_update.sv | 138 +++++++++++++
 tb/tb_neuron_state_update.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_state_update.sv
// neuron_state_update: vmem write-back, spike reset, and spike-word packing
module neuron_state_update #(
    parameter int NUM_NEURONS = 64,
    parameter int VMEM_W      = 8,
    parameter int SPK_WORD    = 16
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           start_clear_i,
    input  logic                           flush_i,
    input  logic                           reset_mode_i,
    input  logic [VMEM_W-1:0]              vth_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic                           in_last_i,
    input  logic [$clog2(NUM_NEURONS)-1:0] in_idx_i,
    input  logic [VMEM_W:0]                in_conv_i,
    input  logic [$clog2(NUM_NEURONS)-1:0] rd_idx_i,
    output logic [VMEM_W-1:0]              rd_vmem_o,
    output logic                           spk_valid_o,
    input  logic                           spk_ready_i,
    output logic [SPK_WORD-1:0]            spk_word_o,
    output logic [$clog2(NUM_NEURONS)-1:0] spk_base_o,
    output logic                           busy_o
);
    localparam int IW = $clog2(NUM_NEURONS);
    localparam int LW = $clog2(SPK_WORD);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, FLUSH} state_t;

    state_t              state_q;
    logic [IW-1:0]       clr_q;
    logic [VMEM_W-1:0]   vmem_q [NUM_NEURONS];
    logic [VMEM_W-1:0]   rd_vmem_q;
    logic [SPK_WORD-1:0] pack_q;
    logic [SPK_WORD-1:0] spk_word_q;
    logic [IW-1:0]       spk_base_q;
    logic [IW-1:0]       last_base_q;
    logic                spk_valid_q;
    logic                flush_sent_q;

    logic                accept;
    logic                spike;
    logic                emit;
    logic [VMEM_W-1:0]   v;
    logic [VMEM_W-1:0]   vmem_d;
    logic [LW-1:0]       lane;
    logic [IW-1:0]       base;
    logic [SPK_WORD-1:0] pack_d;

    assign in_ready_o  = (state_q == RUN) && !spk_valid_q;
    assign busy_o      = (state_q == CLEAR) || (state_q == FLUSH);
    assign spk_valid_o = spk_valid_q;
    assign spk_word_o  = spk_word_q;
    assign spk_base_o  = spk_base_q;
    assign rd_vmem_o   = rd_vmem_q;

    // decode of the incoming conv result: new vmem value, pack update, word completion
    always_comb begin
        accept = in_valid_i && in_ready_o;
        v      = in_conv_i[VMEM_W:1];
        spike  = in_last_i && in_conv_i[0];
        vmem_d = !spike ? v : reset_mode_i ? '0 : (v > vth_i ? v - vth_i : '0);
        lane   = in_idx_i[LW-1:0];
        base   = in_idx_i & ~IW'(SPK_WORD - 1);
        pack_d = in_last_i ? (pack_q & ~(SPK_WORD'(1) << lane)) | (SPK_WORD'(in_conv_i[0]) << lane) : pack_q;
        emit   = accept && in_last_i && (&lane);
    end

    // control FSM with the packed-spike output register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            clr_q        <= '0;
            pack_q       <= '0;
            spk_word_q   <= '0;
            spk_base_q   <= '0;
            last_base_q  <= '0;
            spk_valid_q  <= 1'b0;
            flush_sent_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start_clear_i) begin
                    state_q <= CLEAR;
                    clr_q   <= '0;
                end
                CLEAR: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == IW'(NUM_NEURONS - 1)) state_q <= RUN;
                end
                RUN: begin
                    if (spk_valid_q && spk_ready_i) spk_valid_q <= 1'b0;
                    if (accept) begin
                        last_base_q <= base;
                        pack_q      <= emit ? '0 : pack_d;
                        if (emit) begin
                            spk_word_q  <= pack_d;
                            spk_base_q  <= base;
                            spk_valid_q <= 1'b1;
                        end
                    end
                    if (flush_i) begin
                        state_q      <= FLUSH;
                        flush_sent_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    // a word still pending from RUN drains first, then the partial word goes out
                    if (spk_valid_q) begin
                        if (spk_ready_i) begin
                            spk_valid_q <= 1'b0;
                            if (flush_sent_q) state_q <= IDLE;
                        end
                    end else if (!flush_sent_q) begin
                        spk_word_q   <= pack_q;
                        spk_base_q   <= last_base_q;
                        spk_valid_q  <= 1'b1;
                        pack_q       <= '0;
                        flush_sent_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // state array: clear sweep or accepted write, plus read-before-write read port
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_NEURONS; i++) vmem_q[i] <= '0;
            rd_vmem_q <= '0;
        end else begin
            rd_vmem_q <= vmem_q[rd_idx_i];
            if (state_q == CLEAR) vmem_q[clr_q] <= '0;
            else if (accept) vmem_q[in_idx_i] <= vmem_d;
        end
    end
endmodule

// File: tb/tb_neuron_state_update.sv
// tb_neuron_state_update: randomized and directed checks against a behavioural model
module tb_neuron_state_update;
    localparam int N = 64;
    localparam int W = 16;

    logic       clk = 0;
    logic       nrst = 0;
    logic       start_clear = 0, flush = 0, reset_mode = 0, in_valid = 0, in_last = 0, spk_ready = 0;
    logic [7:0] vth = 0;
    logic [5:0] in_idx = 0, rd_idx = 0;
    logic [8:0] in_conv = 0;
    logic       in_ready, spk_valid, busy;
    logic [7:0] rd_vmem;
    logic [15:0] spk_word;
    logic [5:0] spk_base;

    int total = 0, bad = 0;

    neuron_state_update dut (
        .clk(clk), .nrst(nrst), .start_clear_i(start_clear), .flush_i(flush),
        .reset_mode_i(reset_mode), .vth_i(vth), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_last_i(in_last), .in_idx_i(in_idx), .in_conv_i(in_conv), .rd_idx_i(rd_idx),
        .rd_vmem_o(rd_vmem), .spk_valid_o(spk_valid), .spk_ready_i(spk_ready),
        .spk_word_o(spk_word), .spk_base_o(spk_base), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: 0 idle, 1 clearing, 2 running, 3 flushing
    int         phase, cnt, eb, lb;
    int         vm [N];
    bit [15:0]  pk, ew;
    bit         ev, sent, rdy;
    int         erd, mv;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase = 0; cnt = 0; pk = 0; ew = 0; eb = 0; lb = 0; ev = 0; sent = 0; erd = 0;
            for (int i = 0; i < N; i++) vm[i] = 0;
        end else begin
            rdy = (phase == 2) && !ev;
            erd = vm[rd_idx];
            if (phase == 0) begin
                if (start_clear) begin phase = 1; cnt = 0; end
            end else if (phase == 1) begin
                vm[cnt] = 0;
                cnt++;
                if (cnt == N) phase = 2;
            end else if (phase == 2) begin
                if (ev && spk_ready) ev = 0;
                if (in_valid && rdy) begin
                    mv = int'(in_conv) / 2;
                    lb = (int'(in_idx) / W) * W;
                    if (in_last) pk[int'(in_idx) % W] = in_conv[0];
                    if (in_last && in_conv[0]) vm[in_idx] = reset_mode ? 0 : (mv > int'(vth) ? mv - int'(vth) : 0);
                    else vm[in_idx] = mv;
                    if (in_last && int'(in_idx) % W == W - 1) begin
                        ew = pk; eb = lb; ev = 1; pk = 0;
                    end
                end
                if (flush) begin phase = 3; sent = 0; end
            end else begin
                if (ev) begin
                    if (spk_ready) begin ev = 0; if (sent) phase = 0; end
                end else if (!sent) begin
                    ew = pk; eb = lb; ev = 1; pk = 0; sent = 1;
                end
            end
        end
    end

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(phase == 2 && !ev));
        chk("busy", int'(busy), int'(phase == 1 || phase == 3));
        chk("spk_valid", int'(spk_valid), int'(ev));
        chk("rd_vmem", int'(rd_vmem), erd);
        if (ev) begin
            chk("spk_word", int'(spk_word), int'(ew));
            chk("spk_base", int'(spk_base), eb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input bit last, input int v, input bit s);
        int n = 0;
        in_valid = 1; in_last = last; in_idx = 6'(idx); in_conv = {8'(v), s};
        while (!in_ready && n < 100) begin n++; tick(); end
        if (n >= 100) chk("send_timeout", 0, 1);
        tick();
        in_valid = 0;
    endtask

    task automatic rd(input int idx, input int exp, input string name);
        rd_idx = 6'(idx);
        tick();
        chk(name, int'(rd_vmem), exp);
    endtask

    task automatic do_clear();
        int n = 0;
        start_clear = 1; tick(); start_clear = 0;
        while (busy && n < 200) begin n++; tick(); end
        chk("clear_cycles", n, 64);
    endtask

    initial begin
        tick(); tick();
        chk("rst_spk_valid", int'(spk_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        nrst = 1;
        tick();
        do_clear();
        chk("run_in_ready", int'(in_ready), 1);
        rd(5, 0, "rd5_after_clear");
        vth = 40; reset_mode = 0;
        send(3, 1, 100, 1);
        rd(3, 60, "sub_reset");
        send(3, 1, 30, 1);
        rd(3, 0, "sub_saturate");
        reset_mode = 1;
        send(7, 0, 90, 1);
        rd(7, 90, "partial");
        send(7, 1, 90, 1);
        rd(7, 0, "zero_reset");
        send(0, 1, 10, 1);
        send(3, 1, 5, 0);
        rd(3, 5, "no_spike_write");
        send(15, 1, 50, 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", int'(spk_valid), 1);
            chk("hold_word", int'(spk_word), 16'h8081);
            chk("hold_base", int'(spk_base), 0);
            chk("hold_ready", int'(in_ready), 0);
            tick();
        end
        spk_ready = 1; tick(); spk_ready = 0;
        chk("after_xfer_valid", int'(spk_valid), 0);
        chk("after_xfer_ready", int'(in_ready), 1);
        send(17, 1, 20, 1);
        flush = 1; tick(); flush = 0;
        begin
            int n = 0;
            while (!spk_valid && n < 50) begin n++; tick(); end
        end
        chk("flush_valid", int'(spk_valid), 1);
        chk("flush_word", int'(spk_word), 16'h0002);
        chk("flush_base", int'(spk_base), 16);
        spk_ready = 1; tick(); spk_ready = 0;
        chk("flush_idle_busy", int'(busy), 0);
        chk("flush_idle_ready", int'(in_ready), 0);
        do_clear();
        for (int c = 0; c < 1500; c++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_last     = ($urandom % 4) != 0;
            in_idx      = ($urandom % 3 == 0) ? 6'($urandom | 15) : 6'($urandom);
            in_conv     = 9'($urandom);
            spk_ready   = ($urandom % 3) != 0;
            rd_idx      = 6'($urandom);
            vth         = 8'($urandom);
            reset_mode  = 1'($urandom);
            start_clear = ($urandom % 20) == 0;
            flush       = ($urandom % 100) == 0;
            tick();
        end
        in_valid = 0; start_clear = 0; flush = 0; spk_ready = 0;
        nrst = 0; tick(); nrst = 1; tick();
        do_clear();
        reset_mode = 0; vth = 0;
        send(15, 1, 9, 1);
        chk("pre_rst_valid", int'(spk_valid), 1);
        #2 nrst = 0;
        #1;
        chk("async_rst_valid", int'(spk_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(in_ready), 0);
        nrst = 1;
        rd(15, 0, "rd_after_async_rst");
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
